// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked adder.
//   state_t : operation phase (IDLE accept, RUN chunk loop, DONE result hold)
//   clog2   : ceiling log2, used to size the chunk counter
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple slice.
//   x, y  : chunk operands
//   ci    : carry into bit 0
//   s     : chunk sum
//   co    : carry out of the top bit
//   c_msb : carry into the top bit (signed overflow = c_msb ^ co)
module adder_slice #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] full;

  always_comb begin
    full  = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    s     = full[CHUNK-1:0];
    co    = full[CHUNK];
    // The top sum bit is x^y^carry_in, so the carry into it falls out directly.
    c_msb = x[CHUNK-1] ^ y[CHUNK-1] ^ full[CHUNK-1];
  end

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle two's-complement adder/subtractor, CHUNK bits per clock with the
// ripple carry held in a register between chunks.
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, cin, sub)
//   sub                  : 1 -> a - b (cin ignored), 0 -> a + b + cin
//   out_valid / out_ready: result handshake (sum, cout, ovf)
//   cout                 : carry out of MSB (sub mode: 1 = no borrow)
//   ovf                  : signed overflow
module chunked_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (clog2(NCHUNK) > 0) ? clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry;
  logic [31:0]      base;
  logic [CHUNK-1:0] x, y, s;
  logic             co, c_msb;

  assign base = 32'(count) * CHUNK;
  assign x    = a_q[base +: CHUNK];
  assign y    = b_q[base +: CHUNK];

  adder_slice #(.CHUNK(CHUNK)) u_slice (
    .x     (x),
    .y     (y),
    .ci    (carry),
    .s     (s),
    .co    (co),
    .c_msb (c_msb)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (count == LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert b once and seed the carry.
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            count <= '0;
          end
        end
        RUN: begin
          sum[base +: CHUNK] <= s;
          carry              <= co;
          if (count == LAST) begin
            cout <= co;
            ovf  <= c_msb ^ co;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder: three instances (CHUNK = 8, 32, 1),
// each with its own driver, scoreboard queue and monitor.
module tb_chunked_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the whole word.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    longint      sa, sb, r;
    logic [32:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      r      = sa - sb;
      e.cout = (a >= b);
    end else begin
      r      = sa + sb + longint'(cin);
      u      = {1'b0, a} + {1'b0, b} + 33'(cin);
      e.cout = u[32];
    end
    e.sum = r[31:0];
    e.ovf = (r > longint'(32'sh7FFF_FFFF)) || (r < longint'(32'sh8000_0000));
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [31:0] rop();
    case ($urandom_range(0, 3))
      0, 1:    return $urandom;
      2:       return $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      default: return $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : 32'hFFFF_FFFF;
    endcase
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int unsigned CH  = (k == 0) ? 8 : (k == 1) ? 32 : 1;
    localparam int unsigned NCH = 32 / CH;

    logic        reset, in_valid, in_ready, cin, sub, out_valid, out_ready;
    logic        cout, ovf, force_ready, rnd;
    logic [31:0] a, b, sum;
    int          cyc;
    int          last_acc;
    bit          done;
    exp_t        q[$];

    chunked_adder #(.WIDTH(32), .CHUNK(CH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
    );

    function automatic string nm(input string s);
      return $sformatf("c%0d_%s", CH, s);
    endfunction

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
      out_ready = 1'b1;
      forever begin
        @(posedge clk);
        #2;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : force_ready;
      end
    end

    // Monitor: latency on the rising edge of out_valid, values at handshake.
    initial begin
      bit   pv;
      exp_t e;
      pv = 1'b0;
      forever begin
        @(negedge clk);
        if (reset) pv = 1'b0;
        else begin
          if (out_valid && !pv) begin
            if (q.size() == 0) chk(nm("spurious_valid"), out_valid, 1'b0);
            else chk(nm("latency"), cyc - q[0].acc, NCH);
          end
          if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk(nm("sum"), sum, e.sum);
            chk(nm("cout"), cout, e.cout);
            chk(nm("ovf"), ovf, e.ovf);
          end
          pv = out_valid;
        end
      end
    end

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                         input logic ic, input logic is, input bit push);
      exp_t e;
      bit   ok;
      a = ia; b = ib; cin = ic; sub = is; in_valid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk(nm("accept_timeout"), in_ready, 1'b1);
      else begin
        last_acc = cyc + 1;
        if (push) begin
          e     = model(ia, ib, ic, is);
          e.acc = last_acc;
          q.push_back(e);
        end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic drain();
      for (int n = 0; n < 1000 && q.size() > 0; n++) @(posedge clk);
      chk(nm("drain"), q.size(), 0);
      #1;
    endtask

    initial begin
      exp_t e1;
      int   rel;
      int   d;
      done = 1'b0;
      reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      force_ready = 1'b1; rnd = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(nm("rst_in_ready"), in_ready, 1'b1);
      chk(nm("rst_out_valid"), out_valid, 1'b0);
      chk(nm("rst_sum"), sum, 32'h0);
      chk(nm("rst_cout_ovf"), {cout, ovf}, 2'b00);
      @(posedge clk); #1; reset = 1'b0;

      issue(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
      issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
      issue(32'h0000_0001, 32'h2, 1'b1, 1'b0, 1'b1);
      issue(32'h5, 32'h7, 1'b0, 1'b1, 1'b1);
      issue(32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b1);
      drain();

      // Back-pressure: result must hold, second operand must wait.
      force_ready = 1'b0;
      e1 = model(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0);
      issue(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 1'b1);
      for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
      a = 32'hDEAD_BEEF; b = 32'h0000_1111; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
      for (int n = 0; n < 5; n++) begin
        @(negedge clk);
        chk(nm("hold_in_ready"), in_ready, 1'b0);
        chk(nm("hold_out_valid"), out_valid, 1'b1);
        chk(nm("hold_sum"), sum, e1.sum);
        chk(nm("hold_flags"), {cout, ovf}, {e1.cout, e1.ovf});
      end
      @(posedge clk); #1;
      force_ready = 1'b1;
      rel = cyc;
      issue(32'hDEAD_BEEF, 32'h0000_1111, 1'b0, 1'b1, 1'b1);
      chk(nm("accept_after_release"), last_acc, rel + 2);
      drain();

      // Reset mid-operation discards the partial result.
      d = (NCH > 2) ? 2 : NCH - 1;
      issue(32'h9, 32'h9, 1'b0, 1'b0, 1'b0);
      if (d > 0) begin
        repeat (d) @(posedge clk);
        #1;
      end
      reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      chk(nm("midrst_in_ready"), in_ready, 1'b1);
      chk(nm("midrst_out_valid"), out_valid, 1'b0);
      chk(nm("midrst_sum"), sum, 32'h0);
      @(posedge clk); #1;
      issue(32'h3, 32'h4, 1'b0, 1'b0, 1'b1);
      drain();

      rnd = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        issue(rop(), rop(), 1'($urandom), 1'($urandom), 1'b1);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      drain();
      rnd = 1'b0;
      done = 1'b1;
    end
  end

  initial begin
    bit all;
    all = 1'b0;
    for (int n = 0; n < 95000 && !all; n++) begin
      @(posedge clk);
      all = g[0].done && g[1].done && g[2].done;
    end
    chk("all_done", all, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
